// File: rtl/uio_uart_pkg.sv
// Shared constants and state encoding for the uio UART transmitter.
//   DATA_BITS / FRAME_BITS : 8N1 frame geometry
//   DEFAULT_CLKS_PER_BIT   : bit period for a 25 MHz clock at 115200 baud
//   ST_*                   : transmitter FSM state codes
package uio_uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned FRAME_BITS           = 10;
    localparam int unsigned CLK_HZ               = 25_000_000;
    localparam int unsigned BAUD_RATE            = 115_200;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD_RATE;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for the UART transmitter.
//   clk, rst      : clock, synchronous active-high reset (flushes contents)
//   push, wdata   : write request / data (ignored while not ready)
//   pop           : read request (ignored while empty)
//   rdata_c       : head entry, combinational from the read pointer
//   empty         : registered, FIFO holds no entries
//   ready         : registered, FIFO can accept a push (low during reset)
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             empty,
    output logic             ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && ready;
    assign do_pop  = pop && !empty;
    assign rdata_c = mem[rd_ptr];

    // Occupancy update; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_n = count;
        if (do_push && !do_pop) begin
            count_n = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_n = count - CNT_W'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_n;
            empty <= (count_n == '0);
            ready <= (count_n != CNT_W'(DEPTH));
        end
    end

    // Storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uio_uart_tx.sv
// 8N1 UART transmitter driving uio_out[0] / uio_oe[0].
//   clk, rst  : clock, synchronous active-high reset (aborts frame, flushes FIFO)
//   tx_data   : byte to send, accepted when tx_valid && tx_ready
//   tx_valid  : tx_data is valid
//   tx_ready  : FIFO can accept a byte
//   tx        : registered serial line, idle high
//   tx_oe     : output enable, low only during reset
//   busy      : registered, frame in progress or bytes queued
module uio_uart_tx
    import uio_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_oe,
    output logic                 busy
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          state_n;
    logic [BAUD_W-1:0]    baud;
    logic [BAUD_W-1:0]    baud_n;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_n;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_n;
    logic                 baud_tc_c;
    logic                 pop_c;
    logic                 push_c;
    logic                 tx_c;
    logic [DATA_BITS-1:0] fifo_rdata_c;
    logic                 fifo_empty;
    logic                 fifo_ready;

    assign push_c   = tx_valid && fifo_ready;
    assign tx_ready = fifo_ready;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .wdata   (tx_data),
        .pop     (pop_c),
        .rdata_c (fifo_rdata_c),
        .empty   (fifo_empty),
        .ready   (fifo_ready)
    );

    assign baud_tc_c = (baud == BAUD_LAST);

    // Next-state, baud/bit counters, shift register and line level
    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_cnt;
        shift_n = shift;
        pop_c   = 1'b0;
        tx_c    = 1'b1;

        if (state != ST_IDLE) begin
            baud_n = baud_tc_c ? '0 : baud + BAUD_W'(1);
        end

        case (state)
            ST_IDLE: begin
                baud_n = '0;
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_n = fifo_rdata_c;
                    bit_n   = '0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                tx_c = 1'b0;
                if (baud_tc_c) state_n = ST_DATA;
            end
            ST_DATA: begin
                tx_c = shift[0];
                if (baud_tc_c) begin
                    shift_n = {1'b0, shift[DATA_BITS-1:1]};
                    bit_n   = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_LAST) state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit when data is queued
                if (baud_tc_c) begin
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_n = fifo_rdata_c;
                        bit_n   = '0;
                        state_n = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Datapath and registered pin outputs; tx and busy lag the state by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            tx_oe   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            baud    <= baud_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            tx      <= tx_c;
            tx_oe   <= 1'b1;
            busy    <= (state != ST_IDLE) || !fifo_empty;
        end
    end

endmodule

// File: tb/tb_uio_uart_tx.sv
// Self-checking bench for uio_uart_tx with CLKS_PER_BIT = 4, FIFO_DEPTH = 4.
module tb_uio_uart_tx;
    import uio_uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       tx_oe;
    logic       busy;

    uio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_oe    (tx_oe),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int passed = 0;
    int total  = 0;
    int frames_done = 0;
    int last_wait = 0;
    bit mon_en = 1'b0;
    logic [7:0] expq[$];
    int starts[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line levels in bit order, LSB = start bit
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Drive a byte at a negedge, wait for ready, return edge count of accept
    task automatic send(input logic [7:0] d, input int max_wait, input bit jitter, output int acc);
        int w = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (!tx_ready && w < max_wait) begin
            if (jitter) tx_data = 8'($urandom);
            @(negedge clk);
            w++;
        end
        last_wait = w;
        if (!tx_ready) begin
            fail("send_timeout");
            tx_valid = 1'b0;
            acc = -1;
            return;
        end
        tx_data = d;
        expq.push_back(d);
        @(posedge clk);
        @(negedge clk);
        acc = edge_cnt;
        tx_valid = 1'b0;
    endtask

    task automatic wait_low(input int max_wait, output int at);
        int w = 0;
        while (tx !== 1'b0 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        at = edge_cnt;
        if (tx !== 1'b0) fail("wait_tx_low");
    endtask

    task automatic wait_idle(input int max_wait);
        int w = 0;
        while ((busy !== 1'b0 || tx !== 1'b1) && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        if (busy !== 1'b0) fail("wait_idle");
    endtask

    task automatic wait_frames(input int target, input int max_wait);
        int w = 0;
        while (frames_done < target && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        if (frames_done < target) fail("wait_frames");
    endtask

    // Frame monitor: decodes tx mid-bit and compares against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && tx_oe === 1'b1 && tx === 1'b0) begin
                logic       st;
                logic       sp;
                logic [7:0] got;
                logic [7:0] exp;
                starts.push_back(edge_cnt);
                repeat (CPB / 2) @(negedge clk);
                st = tx;
                for (int i = 0; i < DATA_BITS; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                sp = tx;
                if (expq.size() == 0) begin
                    fail("mon_unexpected_frame");
                end else begin
                    exp = expq.pop_front();
                    check("mon_frame", {22'd0, st, sp, got}, {22'd0, 1'b0, 1'b1, exp});
                end
                frames_done++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int fall;
        int f0;
        int bad;
        logic [9:0] got_frame;
        logic [1:0] tail;

        vecs[0] = '{8'hA5, 10'h34A};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'h3C, 10'h278};
        vecs[4] = '{8'h81, 10'h302};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {28'd0, tx, tx_oe, tx_ready, busy}, 32'b1000);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset", {30'd0, tx_oe, tx_ready}, 32'b11);
        mon_en = 1'b1;

        // Single frames from idle: latency, bit pattern, busy tail
        foreach (vecs[k]) begin
            wait_idle(200);
            send(vecs[k].data, 10, 1'b0, acc);
            wait_low(20, fall);
            check("latency", 32'(fall - acc), 32'd2);
            repeat (CPB / 2) @(negedge clk);
            for (int b = 0; b < FRAME_BITS; b++) begin
                got_frame[b] = tx;
                if (b != FRAME_BITS - 1) repeat (CPB) @(negedge clk);
            end
            check("frame_bits", {22'd0, got_frame}, {22'd0, vecs[k].frame});
            @(negedge clk);
            tail[1] = busy;
            @(negedge clk);
            tail[0] = busy;
            check("busy_tail", {30'd0, tail}, 32'b10);
        end

        // Back-to-back frames
        wait_idle(200);
        starts.delete();
        f0 = frames_done;
        send(8'h00, 10, 1'b0, acc);
        send(8'hFF, 10, 1'b0, acc);
        send(8'h3C, 10, 1'b0, acc);
        wait_frames(f0 + 3, 3 * FRAME + 20);
        if (starts.size() >= 3) begin
            check("b2b_gap01", 32'(starts[1] - starts[0]), 32'(FRAME));
            check("b2b_gap12", 32'(starts[2] - starts[1]), 32'(FRAME));
        end else begin
            fail("b2b_starts");
        end

        // FIFO full: four queued behind an active frame, fifth held with jittering data
        wait_idle(200);
        starts.delete();
        f0 = frames_done;
        send(8'h12, 10, 1'b0, acc);
        wait_low(20, fall);
        send(8'h34, 2, 1'b0, acc);
        send(8'h56, 2, 1'b0, acc);
        send(8'h78, 2, 1'b0, acc);
        check("ready_before_full", {31'd0, tx_ready}, 32'd1);
        send(8'h9A, 2, 1'b0, acc);
        check("ready_full", {31'd0, tx_ready}, 32'd0);
        send(8'hC3, 3 * FRAME, 1'b1, acc);
        check("fifth_held", {31'd0, (last_wait > 0)}, 32'd1);
        if (starts.size() >= 1) check("fifth_accept_edge", 32'(acc - starts[0]), 32'(FRAME));
        else fail("full_starts");
        wait_frames(f0 + 6, 7 * FRAME);
        check("queue_drained", 32'(expq.size()), 32'd0);

        // Reset during DATA bit 3 of 0x55 with two bytes queued
        wait_idle(200);
        mon_en = 1'b0;
        send(8'h55, 10, 1'b0, acc);
        send(8'h11, 10, 1'b0, acc);
        send(8'h22, 10, 1'b0, acc);
        wait_low(20, fall);
        repeat (4 + 3 * CPB + 1) @(negedge clk);
        check("pre_reset_bit3", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset", {28'd0, tx, tx_oe, busy, tx_ready}, 32'b1000);
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        @(negedge clk);
        check("reset_release", {28'd0, tx_oe, tx_ready, tx, busy}, 32'b1110);

        // Quiet line after reset; monitor flags any frame
        mon_en = 1'b1;
        f0 = frames_done;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_oe !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);
        check("no_frames_after_reset", 32'(frames_done - f0), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uio_uart_tx.md
# uio_uart_tx

Byte-serial UART transmitter that drives one bidirectional pin of the tt_um_devinatkin_demond tile (uio_out[0], with uio_oe[0]). It is the outbound counterpart to the pin-level stimulus the top-level bench applies to uio_in. Game logic pushes status/score bytes through a valid/ready port into a small FIFO, and the block serialises them as 8N1 frames for the host or test harness. It is instantiated inside the top module, and its outputs map directly onto the uio pins.

## Interface
Parameters:
- CLKS_PER_BIT, default 217: clock cycles per serial bit (25 MHz / 115200); legal range ≥ 2.
- FIFO_DEPTH, default 4: byte FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset: synchronous, active-high.
- tx_data  input  8  byte to send.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  FIFO can accept a byte.
- tx  output  1  serial line, idle high; drives uio_out[0].
- tx_oe  output  1  output enable; drives uio_oe[0].
- busy  output  1  frame in progress or FIFO non-empty.

## Operation
- Handshake:
  - A byte is pushed on any rising edge with tx_valid && tx_ready.
  - tx_ready = !full, computed from the registered count. It does not depend on a same-cycle pop, so a full FIFO accepts nothing even while popping.
  - While tx_ready = 0, tx_data must be held stable with tx_valid.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx = 1. If the FIFO is non-empty: pop into the shift register, clear the bit counter, go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift[0], LSB first. Shift right every CLKS_PER_BIT cycles. After 8 bits, go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles.
    - At the end of STOP, if the FIFO is non-empty, pop and go directly to START, giving back-to-back frames with no idle cycles.
    - Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. The state or bit advances on the terminal count. Counter width is $clog2(CLKS_PER_BIT).
- tx is a registered output (no combinational path from FSM to pin).
- busy = (state != IDLE) || !empty.
- tx_oe = 0 while rst is asserted, 1 from the first clock after rst deasserts. The pin is never tri-stated during operation.

## Timing
- Reset values: tx = 1, tx_oe = 0, tx_ready = 0 during reset and 1 on the first cycle after, busy = 0. FIFO empty, state IDLE, counters 0.
- Latency: a byte accepted at edge N when IDLE and the FIFO is empty produces the tx falling edge at edge N+2.
- Frame length: exactly 10 × CLKS_PER_BIT cycles.
- FIFO full:
  - tx_ready deasserts the cycle after the FIFO_DEPTH-th push.
  - It reasserts the cycle after the pop that frees an entry.
- FIFO empty: a push and the IDLE check in the same cycle do not pop that cycle. The pop occurs the next cycle, which is consistent with the N+2 latency.
- Simultaneous push and pop when not full: both occur and the count is unchanged.
- Reset mid-frame:
  - The frame is aborted and the FIFO is flushed.
  - tx = 1 and tx_oe = 0 from the edge where rst is sampled high.
  - No partial frame resumes after reset.

## Structure
- Package uio_uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - the FRAME_BITS = 10 and DATA_BITS = 8 constants;
  - the default CLKS_PER_BIT for a 25 MHz clock.
- One sub-module, uart_tx_fifo: synchronous FIFO with push/pop, full/empty flags and count, parameterised by width and depth, with pointer wrap via power-of-two depth. The FSM, baud counter and shift register stay in uio_uart_tx.

## Test plan
All scenarios use CLKS_PER_BIT = 4.
- Single byte 0xA5 pushed from IDLE -> tx falls 2 cycles after accept; bits sampled mid-bit read 1,0,1,0,0,1,0,1; stop high; frame lasts 40 cycles; busy drops the cycle after STOP ends.
- Bytes 0x00, 0xFF, 0x3C pushed on consecutive cycles -> three contiguous frames (120 cycles), no idle between the STOP of one and the START of the next, data correct.
- Five pushes attempted with FIFO_DEPTH = 4 while a frame is in progress -> tx_ready low after the 4th accept; the 5th byte is held and accepted only after the first pop; all five bytes are transmitted in order.
- rst asserted during DATA bit 3 of 0x55 with two bytes queued -> tx = 1, tx_oe = 0, busy = 0 on the next cycle; after release, no bytes are emitted.
- tx_valid held with changing data while tx_ready = 0 -> no push occurs; the byte present at the handshake edge is the one transmitted.
- After reset release -> tx_oe = 1 and tx = 1 steady for 100 idle cycles with no spurious low pulse.
